// File: rtl/jt6295_pkg.sv
// Shared definitions for the JT6295 ROM arbiter: widths, requester
// indexing (channels 0..3, header at index NCH), FSM encoding and helpers.
package jt6295_pkg;
  localparam int AW       = 18;
  localparam int NCH      = 4;
  localparam int NREQ     = NCH + 1;
  localparam int HDR      = NCH;
  localparam int TOUT_DEF = 1023;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DLVR} state_t;

  // One-hot channel grant to binary index (0 when nothing is set)
  function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NCH; i++)
      if (oh[i]) oh2idx = 2'(i);
  endfunction
endpackage

// File: rtl/jt6295_rr4.sv
// Four-way round-robin pick: search starts at ptr+1 and wraps, first
// pending channel found gets the one-hot grant.
module jt6295_rr4
  import jt6295_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [1:0]     ptr,
  output logic [NCH-1:0] gnt
);

  // Walk the four slots after the pointer, keep only the first hit
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    gnt = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = ptr + 2'(i);
      if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Shares one byte-wide ROM port between the header fetcher (highest
// priority) and four ADPCM channels (round-robin). Each requester keeps its
// last served address so a steady cs with an unchanged address is not
// refetched and its ok/dout simply hold.
// Optional build macro JT6295_ROM_ARB_TOUT_EN adds a WAIT-state timeout of
// TOUT cycles that delivers 8'h00 and sets the sticky tout_err flag.
module jt6295_rom_arb
  import jt6295_pkg::*;
#(
  parameter int TOUT = TOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_cs,
  input  logic [AW-1:0]         hdr_addr,
  output logic [7:0]            hdr_dout,
  output logic                  hdr_ok,
  input  logic [NCH-1:0]        ch_cs,
  input  logic [NCH*AW-1:0]     ch_addr,
  output logic [NCH*8-1:0]      ch_dout,
  output logic [NCH-1:0]        ch_ok,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_cs,
  input  logic [7:0]            rom_data,
  input  logic                  rom_ok,
  output logic                  tout_err
);

  if (TOUT < 1) begin : g_tout_chk
    $error("jt6295_rom_arb: TOUT must be at least 1");
  end

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          cs_v, pend, vld_q, ok_q, drop_q;
  logic [NREQ-1:0][AW-1:0]  addr_v, last_q;
  logic [NREQ-1:0][7:0]     dout_q;
  logic [NCH-1:0]           ch_gnt;
  logic [1:0]               ptr_q;
  logic [2:0]               win_q, win_d;
  logic                     tmo;

  assign cs_v   = {hdr_cs, ch_cs};
  assign addr_v = {hdr_addr, ch_addr};

  assign ch_dout  = dout_q[NCH-1:0];
  assign ch_ok    = ok_q[NCH-1:0];
  assign hdr_dout = dout_q[HDR];
  assign hdr_ok   = ok_q[HDR];

  // A requester wants service when its address is new or never served
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++)
      pend[i] = cs_v[i] && (!vld_q[i] || addr_v[i] != last_q[i]);
  end

  jt6295_rr4 u_rr (
    .req (pend[NCH-1:0]),
    .ptr (ptr_q),
    .gnt (ch_gnt)
  );

  // Header beats every channel; otherwise take the round-robin winner
  always_comb begin
    win_d = {1'b0, oh2idx(ch_gnt)};
    if (pend[HDR]) win_d = 3'(HDR);
  end

`ifdef JT6295_ROM_ARB_TOUT_EN
  localparam int CW = $clog2(TOUT + 1);
  logic [CW-1:0] tcnt;
  logic          terr;

  assign tmo      = (state_q == WAIT) && (tcnt == CW'(TOUT - 1));
  assign tout_err = terr;

  // Count WAIT cycles; the flag stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      terr <= 1'b0;
    end else begin
      tcnt <= (state_q == WAIT && !rom_ok && !tmo) ? tcnt + 1'b1 : '0;
      if (tmo && !rom_ok) terr <= 1'b1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign tout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one ISSUE cycle, then wait for the ROM (or a timeout)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|pend) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (rom_ok || tmo) state_d = DLVR;
      DLVR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: ROM port, per-requester bookkeeping and ok/dout outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      win_q    <= '0;
      ptr_q    <= 2'd3;
      vld_q    <= '0;
      last_q   <= '0;
      dout_q   <= '0;
      ok_q     <= '0;
      drop_q   <= '0;
    end else begin
      // ok falls as soon as a new request shows up, or right after a
      // delivery whose requester moved on while the fetch was in flight
      for (int i = 0; i < NREQ; i++)
        if (pend[i] || drop_q[i]) ok_q[i] <= 1'b0;
      drop_q <= '0;
      unique case (state_q)
        IDLE: if (|pend) begin
          win_q    <= win_d;
          rom_cs   <= 1'b1;
          rom_addr <= addr_v[win_d];
        end
        WAIT: if (rom_ok || tmo) begin
          dout_q[win_q] <= rom_ok ? rom_data : 8'h00;
          vld_q[win_q]  <= 1'b1;
          last_q[win_q] <= rom_addr;
        end
        DLVR: begin
          ok_q[win_q] <= 1'b1;
          rom_cs      <= 1'b0;
          if (win_q != 3'(HDR)) ptr_q <= win_q[1:0];
          if (!cs_v[win_q] || addr_v[win_q] != rom_addr) drop_q[win_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb (default build, no timeout). A small
// ROM model answers rom_ok a programmable number of cycles after rom_cs
// rises, with data derived from the address; grants are logged from the
// rising edges of rom_cs.
module tb_jt6295_rom_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_cs;
  logic [17:0] hdr_addr;
  logic [7:0]  hdr_dout;
  logic        hdr_ok;
  logic [3:0]  ch_cs;
  logic [71:0] ch_addr;
  logic [31:0] ch_dout;
  logic [3:0]  ch_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        tout_err;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int rom_lat = 1;
  bit rom_auto = 1'b1;
  int cs_age = 0;
  bit prev_cs = 1'b0;
  logic [17:0] glog[$];

  jt6295_rom_arb dut (
    .clk(clk), .rst(rst),
    .hdr_cs(hdr_cs), .hdr_addr(hdr_addr), .hdr_dout(hdr_dout), .hdr_ok(hdr_ok),
    .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_dout(ch_dout), .ch_ok(ch_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic okv(input int i);
    return (i == 4) ? hdr_ok : ch_ok[i];
  endfunction

  // Advance one cycle, log grants and run the ROM model
  task automatic tick();
    @(posedge clk); #1;
    if (rom_cs && !prev_cs) glog.push_back(rom_addr);
    prev_cs = rom_cs;
    cs_age  = rom_cs ? cs_age + 1 : 0;
    if (rom_auto) begin
      rom_ok   = rom_cs && (cs_age == rom_lat + 1);
      rom_data = rom_fn(rom_addr);
    end
  endtask

  task automatic set_ch(input int i, input logic cs, input logic [17:0] a);
    ch_cs[i] = cs;
    ch_addr[i*18 +: 18] = a;
  endtask

  task automatic wait_ok(input int i, input int lim, output int n);
    n = 0;
    while (!okv(i) && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hdr_cs = 1'b0; hdr_addr = '0; ch_cs = '0; ch_addr = '0;
    rom_ok = 1'b0; rom_data = '0; rom_auto = 1'b1;
    tick(); tick();
    rst = 1'b0;
    glog.delete();
    prev_cs = 1'b0;
    cs_age = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++; if (rom_cs !== 1'b0) begin err_cnt++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    cmp_cnt++; if (rom_addr !== 18'h0) begin err_cnt++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    cmp_cnt++; if (ch_ok !== 4'h0) begin err_cnt++; $display("FAIL reset_ch_ok: got %h want 0", ch_ok); end
    cmp_cnt++; if (hdr_ok !== 1'b0) begin err_cnt++; $display("FAIL reset_hdr_ok: got %b want 0", hdr_ok); end
    cmp_cnt++; if (ch_dout !== 32'h0) begin err_cnt++; $display("FAIL reset_ch_dout: got %h want 0", ch_dout); end
    cmp_cnt++; if (hdr_dout !== 8'h0) begin err_cnt++; $display("FAIL reset_hdr_dout: got %h want 0", hdr_dout); end
    cmp_cnt++; if (tout_err !== 1'b0) begin err_cnt++; $display("FAIL reset_tout_err: got %b want 0", tout_err); end
  endtask

  // ch2 at 0x00100, ROM answers 2 cycles after rom_cs; ok after 5 cycles
  task automatic test_single();
    do_reset();
    rom_lat = 2;
    set_ch(2, 1'b1, 18'h00100);
    tick();
    cmp_cnt++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00100) begin err_cnt++; $display("FAIL single_issue: got cs=%b addr=%h want cs=1 addr=00100", rom_cs, rom_addr); end
    tick(); tick(); tick();
    cmp_cnt++; if (ch_ok[2] !== 1'b0) begin err_cnt++; $display("FAIL single_ok_early: got %b want 0", ch_ok[2]); end
    tick();
    cmp_cnt++; if (ch_ok[2] !== 1'b1) begin err_cnt++; $display("FAIL single_ok_c5: got %b want 1", ch_ok[2]); end
    cmp_cnt++; if (ch_dout[16 +: 8] !== 8'hA4) begin err_cnt++; $display("FAIL single_dout: got %h want a4", ch_dout[16 +: 8]); end
    tick();
    cmp_cnt++; if (ch_ok[2] !== 1'b1 || rom_cs !== 1'b0) begin err_cnt++; $display("FAIL single_hold: got ok=%b cs=%b want ok=1 cs=0", ch_ok[2], rom_cs); end
    // cs low keeps outputs; cs back high at the same address does not refetch
    ch_cs[2] = 1'b0;
    tick(); tick(); tick();
    cmp_cnt++; if (ch_ok[2] !== 1'b1 || ch_dout[16 +: 8] !== 8'hA4) begin err_cnt++; $display("FAIL cs_low_hold: got ok=%b dout=%h want ok=1 dout=a4", ch_ok[2], ch_dout[16 +: 8]); end
    ch_cs[2] = 1'b1;
    tick(); tick(); tick();
    cmp_cnt++; if (glog.size() !== 1 || ch_ok[2] !== 1'b1) begin err_cnt++; $display("FAIL same_addr_norefetch: got grants=%0d ok=%b want grants=1 ok=1", glog.size(), ch_ok[2]); end
  endtask

  // All five request together: hdr, ch0, ch1, ch2, ch3
  task automatic test_priority();
    logic [17:0] exp_a [5];
    int n;
    do_reset();
    rom_lat = 1;
    exp_a = '{18'h20000, 18'h00010, 18'h00021, 18'h00032, 18'h00043};
    hdr_cs = 1'b1; hdr_addr = exp_a[0];
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, exp_a[i+1]);
    wait_ok(4, 20, n);
    cmp_cnt++; if (n !== 4) begin err_cnt++; $display("FAIL min_latency: got %0d cycles want 4", n); end
    n = 0;
    while (!(ch_ok === 4'hF) && n < 80) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      cmp_cnt++;
      if (k >= glog.size() || glog[k] !== exp_a[k]) begin
        err_cnt++;
        $display("FAIL prio_grant%0d: got %h want %h", k, (k < glog.size()) ? glog[k] : 18'h3FFFF, exp_a[k]);
      end
    end
    cmp_cnt++; if (hdr_dout !== rom_fn(exp_a[0])) begin err_cnt++; $display("FAIL prio_hdr_dout: got %h want %h", hdr_dout, rom_fn(exp_a[0])); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (ch_dout[i*8 +: 8] !== rom_fn(exp_a[i+1])) begin err_cnt++; $display("FAIL prio_ch%0d_dout: got %h want %h", i, ch_dout[i*8 +: 8], rom_fn(exp_a[i+1])); end
    end
  endtask

  // ch0 and ch1 request a new address each time they are served
  task automatic test_fairness();
    int n;
    logic [17:0] a0, a1, want;
    do_reset();
    rom_lat = 1;
    a0 = 18'h00100; a1 = 18'h00200;
    set_ch(0, 1'b1, a0);
    set_ch(1, 1'b1, a1);
    n = 0;
    while (glog.size() < 6 && n < 200) begin
      tick();
      n++;
      if (ch_ok[0]) begin a0 = a0 + 1'b1; set_ch(0, 1'b1, a0); end
      if (ch_ok[1]) begin a1 = a1 + 1'b1; set_ch(1, 1'b1, a1); end
    end
    for (int k = 0; k < 6; k++) begin
      want = ((k % 2) == 0) ? 18'(18'h00100 + k/2) : 18'(18'h00200 + k/2);
      cmp_cnt++;
      if (k >= glog.size() || glog[k] !== want) begin
        err_cnt++;
        $display("FAIL fair_grant%0d: got %h want %h", k, (k < glog.size()) ? glog[k] : 18'h3FFFF, want);
      end
    end
  endtask

  // Address changes / cs drops while the fetch is in WAIT
  task automatic test_inflight();
    int n;
    do_reset();
    rom_lat = 3;
    set_ch(1, 1'b1, 18'h00010);
    tick(); tick();
    set_ch(1, 1'b1, 18'h00011);
    tick();
    cmp_cnt++; if (rom_addr !== 18'h00010) begin err_cnt++; $display("FAIL addr_stable: got %h want 00010", rom_addr); end
    tick(); tick(); tick();
    cmp_cnt++; if (ch_ok[1] !== 1'b1 || ch_dout[8 +: 8] !== rom_fn(18'h00010)) begin err_cnt++; $display("FAIL chg_old_byte: got ok=%b dout=%h want ok=1 dout=%h", ch_ok[1], ch_dout[8 +: 8], rom_fn(18'h00010)); end
    tick();
    cmp_cnt++; if (ch_ok[1] !== 1'b0) begin err_cnt++; $display("FAIL chg_ok_fall: got %b want 0", ch_ok[1]); end
    cmp_cnt++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00011) begin err_cnt++; $display("FAIL chg_refetch: got cs=%b addr=%h want cs=1 addr=00011", rom_cs, rom_addr); end
    wait_ok(1, 20, n);
    cmp_cnt++; if (ch_ok[1] !== 1'b1 || ch_dout[8 +: 8] !== rom_fn(18'h00011)) begin err_cnt++; $display("FAIL chg_new_byte: got ok=%b dout=%h want ok=1 dout=%h", ch_ok[1], ch_dout[8 +: 8], rom_fn(18'h00011)); end
    // ch0 drops cs mid-fetch: byte still delivered, ok pulses, no refetch
    set_ch(0, 1'b1, 18'h00030);
    tick(); tick();
    ch_cs[0] = 1'b0;
    tick(); tick(); tick(); tick();
    cmp_cnt++; if (ch_ok[0] !== 1'b1 || ch_dout[0 +: 8] !== rom_fn(18'h00030)) begin err_cnt++; $display("FAIL csdrop_deliver: got ok=%b dout=%h want ok=1 dout=%h", ch_ok[0], ch_dout[0 +: 8], rom_fn(18'h00030)); end
    tick();
    cmp_cnt++; if (ch_ok[0] !== 1'b0 || rom_cs !== 1'b0) begin err_cnt++; $display("FAIL csdrop_fall: got ok=%b cs=%b want ok=0 cs=0", ch_ok[0], rom_cs); end
  endtask

  // One-cycle reset while in WAIT, then a late rom_ok
  task automatic test_reset_in_wait();
    int n;
    do_reset();
    rom_lat = 1;
    set_ch(3, 1'b1, 18'h00040);
    wait_ok(3, 20, n);
    cmp_cnt++; if (ch_ok[3] !== 1'b1) begin err_cnt++; $display("FAIL rw_first: got %b want 1", ch_ok[3]); end
    rom_auto = 1'b0; rom_ok = 1'b0;
    set_ch(3, 1'b1, 18'h00041);
    tick(); tick(); tick();
    rst = 1'b1; ch_cs[3] = 1'b0;
    tick();
    rst = 1'b0;
    cmp_cnt++; if (ch_ok !== 4'h0 || hdr_ok !== 1'b0) begin err_cnt++; $display("FAIL rw_ok_clr: got ch=%h hdr=%b want 0", ch_ok, hdr_ok); end
    cmp_cnt++; if (rom_cs !== 1'b0 || ch_dout !== 32'h0) begin err_cnt++; $display("FAIL rw_port_clr: got cs=%b dout=%h want 0", rom_cs, ch_dout); end
    rom_ok = 1'b1; rom_data = 8'h77;
    tick(); tick(); tick();
    cmp_cnt++; if (ch_ok !== 4'h0 || ch_dout !== 32'h0 || rom_cs !== 1'b0) begin err_cnt++; $display("FAIL rw_late_ok: got ok=%h dout=%h cs=%b want all 0", ch_ok, ch_dout, rom_cs); end
    rom_ok = 1'b0;
    rom_auto = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", cmp_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_fairness();
    test_inflight();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/jt6295_rom_arb.md
JT6295_ROM_ARB -- requirements
Module: jt6295_rom_arb

Interface
REQ-001 SHALL have parameter TOUT, default 1023, ROM wait-cycle limit (used only with the Configuration macro).
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port hdr_cs  in  1  header/address-table fetch request, highest priority.
REQ-005 SHALL have port hdr_addr  in  18  header byte address.
REQ-006 SHALL have ports hdr_dout (out 8) and hdr_ok (out 1), the returned byte and its valid flag.
REQ-007 SHALL have port ch_cs  in  4  per-ADPCM-channel request.
REQ-008 SHALL have port ch_addr  in  4x18  per-channel byte address, packed, ch0 in bits 17:0.
REQ-009 SHALL have ports ch_dout (out 4x8 packed) and ch_ok (out 4), per-channel returned byte and valid flag.
REQ-010 SHALL have ports rom_addr (out 18), rom_cs (out 1), rom_data (in 8) and rom_ok (in 1), the shared ROM port.
REQ-011 SHALL have port tout_err  out  1  sticky flag: a ROM access timed out.

Function
REQ-012 A requester SHALL be pending when its cs=1 and (its address differs from its last-served address or its served-valid bit is 0).
REQ-013 A requester's ok SHALL fall one cycle after it becomes pending and rise only in its delivery cycle; with cs=1 and address unchanged, ok SHALL hold.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and DLVR.
REQ-015 IDLE: if any requester is pending, latch the winner, drive rom_addr and rom_cs=1, and go to ISSUE; otherwise stay, with rom_cs=0.
REQ-016 Winner selection: hdr if pending; else round-robin over the channels, starting at last-granted channel +1 mod 4 (pointer resets to 3, so ch0 wins first).
REQ-017 ISSUE SHALL last exactly 1 cycle with rom_ok ignored, then go to WAIT.
REQ-018 WAIT: on rom_ok=1, capture rom_data into the winner's dout, set its served-valid bit, record its served address, and go to DLVR.
REQ-019 DLVR: assert the winner's ok, drop rom_cs, update the round-robin pointer (channel grants only), and return to IDLE.
REQ-020 Minimum latency from a new request in IDLE to ok=1 SHALL be 4 cycles.
REQ-021 If the winner's address changes or its cs falls before DLVR, the fetched byte SHALL still be delivered as above, ok SHALL be cleared the next cycle, and the requester SHALL re-arbitrate.
REQ-022 ch_cs=0 SHALL NOT clear ch_ok or ch_dout; a channel's outputs change only on its own new request.
REQ-023 Simultaneous hdr and channel requests: hdr SHALL be granted first and the channel next; no requester waits more than 5 grants.
REQ-024 rom_addr SHALL hold stable from ISSUE through DLVR.

Reset
REQ-025 Reset SHALL force: state IDLE, rom_cs=0, rom_addr=0, all dout=0, all ok=0, served-valid=0, RR pointer=3, tout_err=0, timeout counter=0.
REQ-026 Reset asserted mid-access SHALL abandon the access; a rom_ok arriving after reset SHALL be ignored unless in WAIT.

Configuration
REQ-027 Macro JT6295_ROM_ARB_TOUT_EN defined: a counter SHALL run in WAIT; if it reaches TOUT without rom_ok, the winner gets dout=8'h00 and ok=1 via DLVR, and tout_err is set (cleared only by reset).
REQ-028 Macro undefined: WAIT SHALL wait indefinitely, no counter SHALL be synthesized, and tout_err SHALL be tied to 0.

Structure
REQ-029 Package jt6295_pkg SHALL hold the FSM state encoding, address width (18), channel count (4) and default TOUT.
REQ-030 Sub-module jt6295_rr4 SHALL implement the 4-way round-robin pick (pending mask plus pointer in, one-hot grant out).

Verification
REQ-031 Single request: ch2_cs=1, addr=18'h00100, rom_ok 2 cycles after rom_cs -> rom_addr=18'h00100, ch_dout[2]=rom_data, ch_ok[2] rises 5 cycles after the request.
REQ-032 Priority: hdr and ch0..ch3 all request in the same cycle -> grant order hdr, ch0, ch1, ch2, ch3.
REQ-033 Fairness: ch0 and ch1 re-request continuously -> grants alternate ch0, ch1, ch0; neither is granted twice in a row.
REQ-034 Address change in flight: ch1 addr changes 18'h10 -> 18'h11 during WAIT -> ok pulses 1 cycle with the old byte, then falls; a second fetch occurs at 18'h11.
REQ-035 Reset in WAIT: rst=1 for 1 cycle -> all ok=0, rom_cs=0, state IDLE; a late rom_ok produces no delivery.
REQ-036 With JT6295_ROM_ARB_TOUT_EN and TOUT=15: rom_ok held 0 -> after 15 WAIT cycles ch_dout=8'h00, ok=1, tout_err=1.
